// File: rtl/alu_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : alu_issue_ctrl_if
// Brief  : Request, ALU-drive and response signals of the ALU issue controller.
// Rev    : 1.0 - initial release
// ============================================================================
interface alu_issue_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_inst;
  logic [31:0] req_a;
  logic [31:0] req_b;

  logic [31:0] alu_A;
  logic [31:0] alu_B;
  logic [3:0]  alu_INST;
  logic        alu_FirstCyc;
  logic [31:0] alu_Z;
  logic [3:0]  alu_FLAGS;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_z;
  logic [3:0]  rsp_flags;
  logic        rsp_err;

  // Environment side: requester, consumer and the ALU itself
  modport master (
    output req_valid, req_inst, req_a, req_b, rsp_ready, alu_Z, alu_FLAGS,
    input  req_ready, alu_A, alu_B, alu_INST, alu_FirstCyc,
           rsp_valid, rsp_z, rsp_flags, rsp_err
  );

  // Controller side
  modport slave (
    input  req_valid, req_inst, req_a, req_b, rsp_ready, alu_Z, alu_FLAGS,
    output req_ready, alu_A, alu_B, alu_INST, alu_FirstCyc,
           rsp_valid, rsp_z, rsp_flags, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module : alu_issue_ctrl
// Brief  : Serialising issue controller for the 32-bit ALU; one op in flight.
// Rev    : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl #(
  parameter int ALU_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  wire logic              CLOCK,
  input  wire logic              RESET,
  alu_issue_ctrl_if.slave        bus,
  output logic [CNT_W-1:0]       op_count
);

  localparam int         LAT_W       = $clog2(ALU_LAT + 1);
  localparam logic [3:0] C_INST_IDLE = 4'b1110;
  localparam logic [3:0] C_INST_BAD  = 4'b0110;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t             r_state;
  logic               r_req_ready;
  logic [31:0]        r_alu_a;
  logic [31:0]        r_alu_b;
  logic [3:0]         r_alu_inst;
  logic               r_first;
  logic               r_rsp_valid;
  logic [31:0]        r_rsp_z;
  logic [3:0]         r_rsp_flags;
  logic               r_rsp_err;
  logic [CNT_W-1:0]   r_count;
  logic [LAT_W-1:0]   r_wait;
  logic               r_have_class;
  logic               r_last_logic;

  logic               w_req_logic;
  logic [3:0]         w_flags_cap;

  // Logic class is exactly the upper half of the opcode space
  assign w_req_logic = bus.req_inst[3];

  // Carry/overflow are meaningless for logic ops; bit 3 is reserved and forced low
  assign w_flags_cap = {bus.alu_FLAGS[3] & 1'b0,
                        bus.alu_FLAGS[2],
                        r_last_logic ? 2'b00 : bus.alu_FLAGS[1:0]};

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b1;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_inst   <= C_INST_IDLE;
      r_first      <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_z      <= '0;
      r_rsp_flags  <= '0;
      r_rsp_err    <= 1'b0;
      r_count      <= '0;
      r_wait       <= '0;
      r_have_class <= 1'b0;
      r_last_logic <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_req_ready <= 1'b0;
            if (bus.req_inst == C_INST_BAD) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_z     <= '0;
              r_rsp_flags <= '0;
              r_rsp_err   <= 1'b1;
            end else begin
              r_state      <= S_ISSUE;
              r_alu_a      <= bus.req_a;
              r_alu_b      <= bus.req_b;
              r_alu_inst   <= bus.req_inst;
              r_first      <= !r_have_class || (w_req_logic != r_last_logic);
              r_have_class <= 1'b1;
              r_last_logic <= w_req_logic;
            end
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT;
          r_wait  <= LAT_W'(ALU_LAT);
          r_first <= 1'b0;
        end
        S_WAIT: begin
          if (r_wait == LAT_W'(1)) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_z     <= bus.alu_Z;
            r_rsp_flags <= w_flags_cap;
            r_rsp_err   <= 1'b0;
            r_alu_inst  <= C_INST_IDLE;
          end else begin
            r_wait <= r_wait - LAT_W'(1);
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_count     <= r_count + CNT_W'(1);
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready    = r_req_ready;
  assign bus.alu_A        = r_alu_a;
  assign bus.alu_B        = r_alu_b;
  assign bus.alu_INST     = r_alu_inst;
  assign bus.alu_FirstCyc = r_first;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_z        = r_rsp_z;
  assign bus.rsp_flags    = r_rsp_flags;
  assign bus.rsp_err      = r_rsp_err;
  assign op_count         = r_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : tb_alu_issue_ctrl
// Brief  : Directed and randomized bench for alu_issue_ctrl with a model ALU.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;
  localparam int ALU_LAT = 1;
  localparam int CNT_W   = 4;

  logic             CLOCK = 1'b0;
  logic             RESET = 1'b1;
  logic [CNT_W-1:0] op_count;
  int               vectors = 0;
  int               miscompares = 0;

  alu_issue_ctrl_if bus();

  alu_issue_ctrl #(.ALU_LAT(ALU_LAT), .CNT_W(CNT_W)) dut (
    .CLOCK   (CLOCK),
    .RESET   (RESET),
    .bus     (bus),
    .op_count(op_count)
  );

  always #5 CLOCK = ~CLOCK;

  // Reference ALU: returns {flags, z}; flags[3] deliberately set, logic ops set noisy carry/ovf
  function automatic logic [35:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y, z;
    logic        cin;
    logic [32:0] s;
    logic [3:0]  f;
    x = a; y = 32'd0; cin = 1'b0; z = 32'd0; f = 4'd0;
    case (op)
      4'b0000: cin = 1'b1;
      4'b0001: y = 32'hFFFF_FFFF;
      4'b0010: y = b;
      4'b0011: begin y = ~b; cin = 1'b1; end
      4'b0100: begin y = b; cin = 1'b1; end
      4'b0101: begin x = b; y = ~a; cin = 1'b1; end
      4'b0111: begin x = 32'd0; y = ~a; cin = 1'b1; end
      default: ;
    endcase
    if (!op[3]) begin
      s = {1'b0, x} + {1'b0, y} + {32'd0, cin};
      z = s[31:0];
      f[0] = (x[31] == y[31]) && (z[31] != x[31]);
      f[1] = s[32];
    end else begin
      case (op[2:0])
        3'd0: z = a & b;
        3'd1: z = a | b;
        3'd2: z = a ^ b;
        3'd3: z = ~(a & b);
        3'd4: z = ~(a | b);
        3'd5: z = ~(a ^ b);
        3'd6: z = 32'd0;
        default: z = ~a;
      endcase
      f[0] = ^a;
      f[1] = ^b;
    end
    f[2] = (z == 32'd0);
    f[3] = 1'b1;
    return {f, z};
  endfunction

  // ALU with ALU_LAT registered stages
  logic [35:0] alu_pipe [ALU_LAT];
  always @(posedge CLOCK) begin
    alu_pipe[0] <= alu_fn(bus.alu_INST, bus.alu_A, bus.alu_B);
    for (int i = 1; i < ALU_LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
  end
  assign bus.alu_Z     = alu_pipe[ALU_LAT-1][31:0];
  assign bus.alu_FLAGS = alu_pipe[ALU_LAT-1][35:32];

  // Transaction-level model: one op in flight, timed by cycles since acceptance
  logic             m_started = 1'b0;
  logic             m_busy, m_err, m_fc, m_have_class, m_last_logic;
  int               m_cyc;
  logic [3:0]       m_inst;
  logic [31:0]      m_a, m_b;
  logic [CNT_W-1:0] m_count;

  logic        exp_rsp_valid, exp_req_ready, exp_fc, exp_err;
  logic [3:0]  exp_inst, exp_flags;
  logic [31:0] exp_z;
  logic [35:0] exp_res;

  assign exp_rsp_valid = m_busy && (m_err || m_cyc >= ALU_LAT + 1);
  assign exp_req_ready = !m_busy;
  assign exp_inst      = (m_busy && !m_err && m_cyc <= ALU_LAT) ? m_inst : 4'b1110;
  assign exp_fc        = m_busy && !m_err && (m_cyc == 0) && m_fc;
  assign exp_err       = exp_rsp_valid && m_err;
  assign exp_res       = alu_fn(m_inst, m_a, m_b);
  assign exp_z         = m_err ? 32'd0 : exp_res[31:0];
  assign exp_flags     = m_err ? 4'd0 : {1'b0, exp_res[34], m_inst[3] ? 2'b00 : exp_res[33:32]};

  always @(posedge CLOCK) begin
    m_started <= 1'b1;
    if (RESET) begin
      m_busy <= 1'b0; m_cyc <= 0; m_count <= '0; m_have_class <= 1'b0;
      m_last_logic <= 1'b0; m_a <= '0; m_b <= '0; m_err <= 1'b0; m_fc <= 1'b0; m_inst <= 4'd0;
    end else if (m_busy) begin
      if (exp_rsp_valid && bus.rsp_ready) begin
        m_busy  <= 1'b0;
        m_count <= m_count + 1'b1;
      end else begin
        m_cyc <= m_cyc + 1;
      end
    end else if (bus.req_valid) begin
      m_busy <= 1'b1;
      m_cyc  <= 0;
      m_err  <= (bus.req_inst == 4'b0110);
      if (bus.req_inst != 4'b0110) begin
        m_inst       <= bus.req_inst;
        m_a          <= bus.req_a;
        m_b          <= bus.req_b;
        m_fc         <= !m_have_class || (bus.req_inst[3] != m_last_logic);
        m_have_class <= 1'b1;
        m_last_logic <= bus.req_inst[3];
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLOCK) begin
    if (m_started) begin
      chk("req_ready",    bus.req_ready,    exp_req_ready);
      chk("alu_A",        bus.alu_A,        m_a);
      chk("alu_B",        bus.alu_B,        m_b);
      chk("alu_INST",     bus.alu_INST,     exp_inst);
      chk("alu_FirstCyc", bus.alu_FirstCyc, exp_fc);
      chk("rsp_valid",    bus.rsp_valid,    exp_rsp_valid);
      chk("rsp_err",      bus.rsp_err,      exp_err);
      chk("op_count",     op_count,         m_count);
      if (exp_rsp_valid) begin
        chk("rsp_z",     bus.rsp_z,     exp_z);
        chk("rsp_flags", bus.rsp_flags, exp_flags);
      end
    end
  end

  // One op with rsp_ready held high; lat counts edges from acceptance to rsp_valid seen
  task automatic do_op(input logic [3:0] inst, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] z, output logic [3:0] fl, output logic er,
                       output int lat, output logic fc);
    int t;
    @(negedge CLOCK);
    bus.req_valid = 1'b1; bus.req_inst = inst; bus.req_a = a; bus.req_b = b; bus.rsp_ready = 1'b1;
    t = 0;
    while (!bus.req_ready && t < 20) begin @(negedge CLOCK); t++; end
    @(negedge CLOCK);
    bus.req_valid = 1'b0;
    fc  = bus.alu_FirstCyc;
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin @(negedge CLOCK); lat++; end
    if (!bus.rsp_valid) begin
      vectors++; miscompares++;
      $display("FAIL rsp_timeout: rsp_valid got 0 expected 1 at %0t", $time);
    end
    z = bus.rsp_z; fl = bus.rsp_flags; er = bus.rsp_err;
  endtask

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 4))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] z;
    logic [3:0]  fl;
    logic        er, fc;
    int          lat;

    bus.req_valid = 1'b0; bus.req_inst = 4'd0; bus.req_a = 32'd0; bus.req_b = 32'd0;
    bus.rsp_ready = 1'b0;
    RESET = 1'b1;
    repeat (3) @(negedge CLOCK);
    chk("rst_rsp_z",     bus.rsp_z,     32'd0);
    chk("rst_rsp_flags", bus.rsp_flags, 4'd0);
    chk("rst_alu_INST",  bus.alu_INST,  4'b1110);
    chk("rst_op_count",  op_count,      4'd0);
    RESET = 1'b0;

    do_op(4'b0010, 32'd5, 32'd7, z, fl, er, lat, fc);
    chk("add_z", z, 32'd12); chk("add_flags", fl, 4'b0000);
    chk("add_lat", lat, ALU_LAT + 2); chk("add_fc", fc, 1'b1);

    do_op(4'b0011, 32'd0, 32'd1, z, fl, er, lat, fc);
    chk("sub_z", z, 32'hFFFF_FFFF); chk("sub_flags", fl, 4'b0000); chk("sub_fc", fc, 1'b0);

    do_op(4'b0000, 32'h7FFF_FFFF, 32'd0, z, fl, er, lat, fc);
    chk("inc_z", z, 32'h8000_0000); chk("inc_flags", fl, 4'b0001);

    do_op(4'b0010, 32'd1, 32'd2, z, fl, er, lat, fc);
    do_op(4'b1000, 32'hF0F0_F0F0, 32'hFF00_FF00, z, fl, er, lat, fc);
    chk("and_z", z, 32'hF000_F000); chk("and_flags", fl, 4'b0000); chk("and_fc", fc, 1'b1);

    do_op(4'b0110, 32'd123, 32'd456, z, fl, er, lat, fc);
    chk("bad_err", er, 1'b1); chk("bad_z", z, 32'd0); chk("bad_lat", lat, 1);
    chk("bad_alu_INST", bus.alu_INST, 4'b1110); chk("bad_alu_A", bus.alu_A, 32'hF0F0_F0F0);
    @(negedge CLOCK);
    chk("bad_count", op_count, 4'd6);

    // Consumer stall
    bus.req_valid = 1'b1; bus.req_inst = 4'b0010; bus.req_a = 32'd10; bus.req_b = 32'd20;
    bus.rsp_ready = 1'b0;
    @(negedge CLOCK);
    bus.req_valid = 1'b0;
    repeat (ALU_LAT + 1) @(negedge CLOCK);
    repeat (5) begin
      chk("stall_z", bus.rsp_z, 32'd30);
      chk("stall_ready", bus.req_ready, 1'b0);
      @(negedge CLOCK);
    end
    bus.rsp_ready = 1'b1;
    @(negedge CLOCK);
    chk("stall_count", op_count, 4'd7);

    // Reset while waiting on the ALU
    bus.req_valid = 1'b1; bus.req_inst = 4'b1001; bus.req_a = 32'd3; bus.req_b = 32'd4;
    @(negedge CLOCK);
    bus.req_valid = 1'b0;
    @(negedge CLOCK);
    RESET = 1'b1;
    @(negedge CLOCK);
    RESET = 1'b0;
    chk("abort_valid", bus.rsp_valid, 1'b0); chk("abort_count", op_count, 4'd0);
    repeat (3) @(negedge CLOCK);
    chk("abort_valid_late", bus.rsp_valid, 1'b0);
    do_op(4'b1001, 32'h0F00_0000, 32'h0000_00F0, z, fl, er, lat, fc);
    chk("abort_next_fc", fc, 1'b1); chk("or_z", z, 32'h0F00_00F0);

    // Counter wrap
    repeat (14) do_op(4'($urandom_range(0, 15)), rnd_word(), rnd_word(), z, fl, er, lat, fc);
    @(negedge CLOCK);
    chk("count_max", op_count, 4'd15);
    do_op(4'b0100, 32'd1, 32'd1, z, fl, er, lat, fc);
    @(negedge CLOCK);
    chk("count_wrap", op_count, 4'd0);

    // Randomized traffic; every cycle is checked against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLOCK);
      bus.req_valid = ($urandom_range(0, 2) != 0);
      bus.req_inst  = 4'($urandom_range(0, 15));
      bus.req_a     = rnd_word();
      bus.req_b     = rnd_word();
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      RESET         = ($urandom_range(0, 249) == 0);
    end
    @(negedge CLOCK);
    RESET = 1'b0; bus.req_valid = 1'b0; bus.rsp_ready = 1'b1;
    repeat (ALU_LAT + 6) @(negedge CLOCK);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
